// File: rtl/bbox_collector.sv
// Per-frame bounding-box accumulator for the connected-components label stream; drains the table at vsync.
// Optional build macro BBOX_FILTER_EN suppresses records with fewer than MIN_PIXELS pixels.
module bbox_collector #(
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned COORD_WIDTH = 10,
  parameter int unsigned NUM_LABELS  = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MIN_PIXELS  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [LABEL_WIDTH-1:0] label,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic [COORD_WIDTH-1:0] out_x_min,
  output logic [COORD_WIDTH-1:0] out_x_max,
  output logic [COORD_WIDTH-1:0] out_y_min,
  output logic [COORD_WIDTH-1:0] out_y_max,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int unsigned IDX_W    = (NUM_LABELS > 2) ? $clog2(NUM_LABELS) : 1;
  localparam int unsigned LAST_IDX = NUM_LABELS - 1;
`ifdef BBOX_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  // Smallest count that is emitted; 1 means every live entry.
  localparam int unsigned MIN_EMIT = (FILTER_ON && MIN_PIXELS > 1) ? MIN_PIXELS : 1;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x_min;
    logic [COORD_WIDTH-1:0] x_max;
    logic [COORD_WIDTH-1:0] y_min;
    logic [COORD_WIDTH-1:0] y_max;
    logic [CNT_WIDTH-1:0]   count;
  } entry_t;

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t                 state_q, state_d;
  entry_t                 tbl_q [NUM_LABELS];
  logic [COORD_WIDTH-1:0] x_q, y_q;
  logic [IDX_W-1:0]       scan_q;
  logic [IDX_W-1:0]       lidx_c;
  entry_t                 cur_c, acc_c;
  logic                   pixel_c, frame_end_c, label_ok_c, label_bad_c;
  logic                   keep_c, last_c, scan_adv_c, load_c, done_c;

  assign pixel_c     = en && !hsync && !vsync;
  assign frame_end_c = en && !hsync && vsync;
  assign label_ok_c  = (label != '0) && (32'(label) < NUM_LABELS);
  assign label_bad_c = 32'(label) >= NUM_LABELS;
  assign lidx_c      = IDX_W'(label);
  assign cur_c       = tbl_q[scan_q];
  assign keep_c      = 32'(cur_c.count) >= MIN_EMIT;
  assign last_c      = scan_q == IDX_W'(LAST_IDX);
  assign busy        = state_q == DUMP;

  // Read-modify-write of the addressed entry; empty entries are seeded from the pixel.
  always_comb begin
    acc_c = tbl_q[lidx_c];
    if (acc_c.count == '0) begin
      acc_c.x_min = x_q;
      acc_c.x_max = x_q;
      acc_c.y_min = y_q;
      acc_c.y_max = y_q;
      acc_c.count = CNT_WIDTH'(1);
    end else begin
      if (x_q < acc_c.x_min) acc_c.x_min = x_q;
      if (x_q > acc_c.x_max) acc_c.x_max = x_q;
      if (y_q < acc_c.y_min) acc_c.y_min = y_q;
      if (y_q > acc_c.y_max) acc_c.y_max = y_q;
      if (acc_c.count != '1) acc_c.count = acc_c.count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  // Scan control: a held record advances on handshake, empty or filtered entries advance at once.
  always_comb begin
    state_d    = state_q;
    scan_adv_c = 1'b0;
    load_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      ACCUM: if (frame_end_c) state_d = DUMP;
      DUMP: begin
        if (out_valid)                         scan_adv_c = out_ready;
        else if (cur_c.count == '0 || !keep_c) scan_adv_c = 1'b1;
        else                                   load_c     = 1'b1;
        if (scan_adv_c && last_c) begin
          done_c  = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      scan_q     <= '0;
      out_valid  <= 1'b0;
      out_label  <= '0;
      out_x_min  <= '0;
      out_x_max  <= '0;
      out_y_min  <= '0;
      out_y_max  <= '0;
      out_count  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_LABELS; i++) tbl_q[i] <= '0;
    end else begin
      frame_done <= done_c;
      if (en) begin
        if (hsync) begin
          x_q <= '0;
          y_q <= y_q + COORD_WIDTH'(1);
        end else if (vsync) begin
          x_q <= '0;
          y_q <= '0;
        end else begin
          x_q <= x_q + COORD_WIDTH'(1);
        end
      end
      if (state_q == ACCUM && pixel_c && label_ok_c) tbl_q[lidx_c] <= acc_c;
      if (state_q == ACCUM && frame_end_c) scan_q <= IDX_W'(1);
      if (scan_adv_c) begin
        tbl_q[scan_q] <= '0;
        scan_q        <= scan_q + IDX_W'(1);
      end
      if (load_c) begin
        out_valid <= 1'b1;
        out_label <= LABEL_WIDTH'(scan_q);
        out_x_min <= cur_c.x_min;
        out_x_max <= cur_c.x_max;
        out_y_min <= cur_c.y_min;
        out_y_max <= cur_c.y_max;
        out_count <= cur_c.count;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Sticky until the dump that reports it finishes.
      if (done_c)
        overflow <= 1'b0;
      else if (pixel_c && (state_q == DUMP || label_bad_c))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bbox_collector.sv
// Directed bench for bbox_collector: single-pixel frame table plus blob, backpressure, filter,
// saturation (CNT_WIDTH=4) and reset-mid-dump sequences.
module tb_bbox_collector;

  localparam int unsigned LW = 8;
  localparam int unsigned CW = 10;
  localparam int unsigned NW = 4;
`ifdef BBOX_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic          clk, reset_n, en, hsync, vsync, out_ready;
  logic [LW-1:0] label, out_label;
  logic [CW-1:0] out_x_min, out_x_max, out_y_min, out_y_max;
  logic [NW-1:0] out_count;
  logic          out_valid, busy, frame_done, overflow;

  int checks = 0;
  int errors = 0;
  int cur_x  = 0;
  int cur_y  = 0;

  bbox_collector #(
    .LABEL_WIDTH(LW), .COORD_WIDTH(CW), .NUM_LABELS(16), .CNT_WIDTH(NW), .MIN_PIXELS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
    .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
    .out_x_min(out_x_min), .out_x_max(out_x_max), .out_y_min(out_y_min), .out_y_max(out_y_max),
    .out_count(out_count), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic h, input logic v, input logic [LW-1:0] l);
    en = e; hsync = h; vsync = v; label = l;
    @(posedge clk);
    #1;
  endtask

  // Move the bench-tracked raster position to (x,y) and present one labelled pixel there.
  task automatic px_at(input int x, input int y, input logic [LW-1:0] l);
    while (cur_y < y) begin step(1, 1, 0, 0); cur_y++; cur_x = 0; end
    while (cur_x < x) begin step(1, 0, 0, 0); cur_x++; end
    step(1, 0, 0, l);
    cur_x++;
  endtask

  task automatic end_frame();
    step(1, 0, 1, 0);
    cur_x = 0;
    cur_y = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 64) begin step(0, 0, 0, 0); n++; end
    check("valid_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic expect_record(input logic [LW-1:0] l, input int x0, input int x1,
                               input int y0, input int y1, input int c);
    wait_valid();
    check("rec_label", 64'(out_label), 64'(l));
    check("rec_x_min", 64'(out_x_min), 64'(x0));
    check("rec_x_max", 64'(out_x_max), 64'(x1));
    check("rec_y_min", 64'(out_y_min), 64'(y0));
    check("rec_y_max", 64'(out_y_max), 64'(y1));
    check("rec_count", 64'(out_count), 64'(c));
    step(0, 0, 0, 0);
    check("valid_drop", 64'(out_valid), 64'(0));
  endtask

  task automatic finish_dump(input logic exp_ovf, output int n);
    check("ovf_in_dump", 64'(overflow), 64'(exp_ovf));
    n = 0;
    while (!frame_done && n < 64) begin
      check("no_extra_record", 64'(out_valid), 64'(0));
      step(0, 0, 0, 0);
      n++;
    end
    check("frame_done", 64'(frame_done), 64'(1));
    check("ovf_cleared", 64'(overflow), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
    step(0, 0, 0, 0);
    check("frame_done_pulse", 64'(frame_done), 64'(0));
  endtask

  typedef struct {
    logic [LW-1:0] lbl;
    int            x;
    int            y;
    bit            rec;
    bit            ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    logic [63:0] held;
    vecs[0] = '{lbl: 8'd1,   x: 0,  y: 0, rec: 1'b1, ovf: 1'b0};
    vecs[1] = '{lbl: 8'd15,  x: 9,  y: 3, rec: 1'b1, ovf: 1'b0};
    vecs[2] = '{lbl: 8'd0,   x: 2,  y: 1, rec: 1'b0, ovf: 1'b0};
    vecs[3] = '{lbl: 8'd16,  x: 1,  y: 0, rec: 1'b0, ovf: 1'b1};
    vecs[4] = '{lbl: 8'd255, x: 4,  y: 2, rec: 1'b0, ovf: 1'b1};
    vecs[5] = '{lbl: 8'd8,   x: 12, y: 5, rec: 1'b1, ovf: 1'b0};

    reset_n = 1'b0; out_ready = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_n = 1'b1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_outputs", {out_label, out_x_min, out_x_max, out_y_min, out_y_max, out_count}, 64'(0));

    // Single blob with back-to-back same-label pixels.
    px_at(5, 2, 3); px_at(6, 2, 3); px_at(5, 3, 3); px_at(7, 4, 3);
    end_frame();
    expect_record(3, 5, 7, 2, 4, 4);
    finish_dump(1'b0, n);

    // Single-pixel frames, including label 0, the top label and out-of-range labels.
    for (int i = 0; i < 6; i++) begin
      px_at(vecs[i].x, vecs[i].y, vecs[i].lbl);
      end_frame();
      if (vecs[i].rec && !FILTER_ON)
        expect_record(vecs[i].lbl, vecs[i].x, vecs[i].x, vecs[i].y, vecs[i].y, 1);
      finish_dump(vecs[i].ovf, n);
    end

    // Backpressure: record 1 held while a pixel and a vsync arrive during the dump.
    for (int i = 0; i < 4; i++) px_at(i, 0, 1);
    for (int i = 0; i < 4; i++) px_at(i, 1, 2);
    out_ready = 1'b0;
    end_frame();
    check("busy_on_vsync", 64'(busy), 64'(1));
    check("valid_on_vsync", 64'(out_valid), 64'(0));
    step(0, 0, 0, 0);
    held = {1'b1, 8'd1, 10'd0, 10'd3, 10'd0, 10'd0, 4'd4};
    check("first_record", {out_valid, out_label, out_x_min, out_x_max, out_y_min, out_y_max, out_count}, held);
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      step(1, 0, 0, 0);
      else if (i == 5) step(1, 0, 1, 0);
      else             step(0, 0, 0, 0);
      check("held_stable", {out_valid, out_label, out_x_min, out_x_max, out_y_min, out_y_max, out_count}, held);
    end
    check("ovf_pixel_in_dump", 64'(overflow), 64'(1));
    check("busy_after_vsync_in_dump", 64'(busy), 64'(1));
    out_ready = 1'b1;
    cur_x = 0; cur_y = 0;
    expect_record(1, 0, 3, 0, 0, 4);
    expect_record(2, 0, 3, 1, 1, 4);
    finish_dump(1'b1, n);

    // Filter: 3-pixel label 1, 4-pixel label 2; then an empty frame must find both cleared.
    for (int i = 0; i < 3; i++) px_at(i, 0, 1);
    for (int i = 0; i < 4; i++) px_at(i, 1, 2);
    end_frame();
    if (!FILTER_ON) expect_record(1, 0, 2, 0, 0, 3);
    expect_record(2, 0, 3, 1, 1, 4);
    finish_dump(1'b0, n);
    end_frame();
    finish_dump(1'b0, n);
    check("empty_dump_len", 64'(n), 64'(15));

    // Saturation: 20 pixels with a 4-bit count.
    for (int i = 0; i < 20; i++) px_at(i, 0, 5);
    end_frame();
    expect_record(5, 0, 19, 0, 0, 15);
    finish_dump(1'b0, n);

    // Reset while record 1 is pending, then an empty frame.
    for (int i = 0; i < 4; i++) px_at(i, 0, 1);
    px_at(0, 1, 99);
    out_ready = 1'b0;
    end_frame();
    wait_valid();
    reset_n = 1'b0;
    step(0, 0, 0, 0);
    reset_n = 1'b1;
    cur_x = 0; cur_y = 0;
    check("rst_dump_valid", 64'(out_valid), 64'(0));
    check("rst_dump_busy", 64'(busy), 64'(0));
    check("rst_dump_overflow", 64'(overflow), 64'(0));
    step(0, 0, 0, 0);
    check("rst_dump_no_done", 64'(frame_done), 64'(0));
    out_ready = 1'b1;
    end_frame();
    finish_dump(1'b0, n);
    check("post_reset_dump_len", 64'(n), 64'(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbox_collector.md
# bbox_collector

Per-frame bounding-box accumulator that sits directly downstream of the connected-components labeling stage. It consumes the 8-bit label stream, the en/hsync/vsync strobes and the pixel coordinates it tracks itself. For every non-zero label it keeps min/max x, min/max y and a pixel count. At each frame boundary it drains the table as a ready/valid record stream for the detection/overlay logic.

## Interface
- LABEL_WIDTH, 8: width of incoming label; matches `WORD_SIZE`.
- COORD_WIDTH, 10: width of x/y counters and box fields.
- NUM_LABELS, 16: table entries; label 0 is background, so usable labels are 1..NUM_LABELS-1.
- CNT_WIDTH, 16: pixel-count width; the count saturates.
- MIN_PIXELS, 4: minimum count for a record to be emitted (only with `BBOX_FILTER_EN`).
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- en  in  1  stream advance; same strobe as the labeling stage.
- hsync  in  1  new row.
- vsync  in  1  new frame; ends accumulation.
- label  in  LABEL_WIDTH  connected-components output for the current pixel.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts the record.
- out_label  out  LABEL_WIDTH  record label.
- out_x_min, out_x_max, out_y_min, out_y_max  out  COORD_WIDTH each  box bounds, inclusive.
- out_count  out  CNT_WIDTH  pixel count, saturated.
- busy  out  1  high while in the DUMP state.
- frame_done  out  1  one-cycle pulse when the dump completes.
- overflow  out  1  sticky flag: a label ≥ NUM_LABELS, or a pixel arriving while busy, was seen this frame.

## Operation
- Coordinates, when en=1:
  - hsync=1: x←0, y←y+1.
  - else vsync=1: x←0, y←0.
  - else: the cycle is a pixel at (x,y), then x←x+1.
  - Counters wrap modulo 2^COORD_WIDTH. hsync has priority over vsync.
- A cycle with en=0 does nothing to the coordinates or the table.
- States: ACCUM (reset state) and DUMP.
- ACCUM, pixel cycle:
  - label==0: ignored.
  - 1 ≤ label < NUM_LABELS, entry empty (count==0): the entry is initialised to min=max=(x,y), count=1.
  - 1 ≤ label < NUM_LABELS, entry non-empty: min/max are updated with unsigned compares; count is incremented, saturating at 2^CNT_WIDTH-1.
  - label ≥ NUM_LABELS: the pixel is dropped and overflow←1.
- Same-label pixels on back-to-back cycles must accumulate correctly: the update is read-modify-write through flops, with no hazard.
- ACCUM→DUMP: on an en=1, hsync=0, vsync=1 cycle. That cycle carries no pixel. The scan index is set to 1.
- DUMP, per index i (1..NUM_LABELS-1):
  - count==0: skip, 1 cycle.
  - Else, if not emitted (filtered): clear the entry, 1 cycle.
  - Else: load the output registers and assert out_valid. Hold all out_* stable until out_valid&&out_ready. On that handshake, clear the entry and advance.
- After index NUM_LABELS-1: pulse frame_done for 1 cycle, return to ACCUM, and clear overflow on the same edge. The overflow value visible during DUMP is therefore the previous frame's.
- Pixels arriving during DUMP (en=1, no sync) are dropped and overflow←1. vsync during DUMP only resets the coordinates.
- The DUMP scan runs independent of en.
- Records are emitted in ascending label order.

## Timing
- Table update: the entry reflects a pixel on the edge after the pixel cycle.
- vsync accepted at edge t → busy=1 after t. The first qualifying entry at index 1 has out_valid=1 after edge t+1.
- Minimum dump length: NUM_LABELS-1 cycles when no records are emitted. Each emitted record adds stall cycles while out_ready=0.
- out_valid falls on the edge after the handshake, unless the next record is loaded in the same cycle. Back-to-back records need ≥1 scan cycle between them.
- Reset values: out_valid=0, busy=0, frame_done=0, overflow=0, all out_* =0, all table entries cleared, x=y=0, state ACCUM.
- reset_n low mid-DUMP: aborts immediately to the reset values. No frame_done is produced.

## Configuration
- `BBOX_FILTER_EN` defined: entries with 0 < count < MIN_PIXELS are cleared silently during DUMP and never emitted.
- `BBOX_FILTER_EN` not defined: every entry with count>0 is emitted; MIN_PIXELS is unused.

## Test plan
- Single blob: label 3 at (5,2), (6,2), (5,3), (7,4); then vsync; out_ready=1 → one record {3, x 5..7, y 2..4, count 4}, then frame_done.
- Backpressure: labels 1 and 2 with one pixel each (filter off); out_ready=0 for 10 cycles → record 1 held stable with out_valid=1; on release, records 1 then 2.
- Filter: with `BBOX_FILTER_EN` and MIN_PIXELS=4, label 1 with 3 pixels and label 2 with 4 pixels → only label 2 emitted; the next frame starts with both entries cleared.
- Overflow: label 20 with NUM_LABELS=16 → no record for it, overflow=1 through the dump, 0 after frame_done.
- Saturation: CNT_WIDTH=4, 20 pixels of label 5 → out_count=15.
- Reset mid-dump: reset_n low while record 1 is pending → out_valid=0, busy=0; the following frame with no labels produces no records.
